// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/nSS/MOSI, command + data byte decode, 8x8 register file.
// Optional build macro SPI_TARGET_AUTOINC_EN: address advances after every data byte.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCK,
  input  logic       nSS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [2:0] HADDR,
  input  logic       HWE,
  input  logic [7:0] HWD,
  output logic [7:0] HRD,
  output logic       RX_STB,
  output logic [7:0] RX_BYTE
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef SPI_TARGET_AUTOINC_EN
  localparam logic [2:0] ADDR_INC = 3'd1;
`else
  localparam logic [2:0] ADDR_INC = 3'd0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e      state_q, state_d;
  logic [NS-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
  logic        sck_prev_q, nss_prev_q, armed_q;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  next_q, next_d;
  logic        rx_stb_q, rx_stb_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  regs_q [8];
  logic        spi_we;

  logic sck_s, nss_s, mosi_s;
  logic sck_rise, sck_fall, nss_rise, nss_fall;
  logic [7:0] byte_w;

  assign sck_s    = sck_sync_q[NS-1];
  assign nss_s    = nss_sync_q[NS-1];
  assign mosi_s   = mosi_sync_q[NS-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign nss_rise = nss_s & ~nss_prev_q;
  assign nss_fall = ~nss_s & nss_prev_q;
  assign byte_w   = {rx_q[6:0], mosi_s};

  assign MISO    = tx_q[7];
  // armed_q blocks a frame already in progress when reset released
  assign MISO_OE = armed_q & ~nss_s;
  assign HRD     = regs_q[HADDR];
  assign RX_STB  = rx_stb_q;
  assign RX_BYTE = rx_byte_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      nss_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      addr_q      <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      next_q      <= 8'h00;
      rx_stb_q    <= 1'b0;
      rx_byte_q   <= 8'h00;
    end else begin
      sck_sync_q  <= {sck_sync_q[NS-2:0], SCK};
      nss_sync_q  <= {nss_sync_q[NS-2:0], nSS};
      mosi_sync_q <= {mosi_sync_q[NS-2:0], MOSI};
      sck_prev_q  <= sck_s;
      nss_prev_q  <= nss_s;
      armed_q     <= armed_q | nss_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      next_q      <= next_d;
      rx_stb_q    <= rx_stb_d;
      rx_byte_q   <= rx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    next_d    = next_q;
    rx_stb_d  = 1'b0;
    rx_byte_d = rx_byte_q;
    spi_we    = 1'b0;
    if (nss_rise) begin
      state_d = IDLE;
    end else if (nss_fall) begin
      state_d  = CMD;
      tx_d     = ID_BYTE;
      bitcnt_d = 3'd0;
    end else if (state_q != IDLE && !nss_s) begin
      if (sck_rise) begin
        rx_d     = byte_w;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          rx_stb_d  = 1'b1;
          rx_byte_d = byte_w;
          case (state_q)
            CMD: begin
              if (byte_w[7]) begin
                state_d = WDATA;
                addr_d  = byte_w[2:0];
                next_d  = 8'h00;
              end else begin
                state_d = RDATA;
                next_d  = regs_q[byte_w[2:0]];
                addr_d  = byte_w[2:0] + ADDR_INC;
              end
            end
            WDATA: begin
              spi_we = 1'b1;
              addr_d = addr_q + ADDR_INC;
              next_d = 8'h00;
            end
            RDATA: begin
              next_d = regs_q[addr_q];
              addr_d = addr_q + ADDR_INC;
            end
            default: ;
          endcase
        end
      end else if (sck_fall) begin
        tx_d = (bitcnt_q == 3'd0) ? next_q : {tx_q[6:0], 1'b0};
      end
    end
  end

  // SPI write takes priority over a host write to the same register
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      if (RST) begin
        regs_q[i] <= 8'h00;
      end else if (spi_we && addr_q == 3'(i)) begin
        regs_q[i] <= byte_w;
      end else if (HWE && HADDR == 3'(i)) begin
        regs_q[i] <= HWD;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Randomised scoreboard bench for spi_target: frame-level register model, RX/MISO and host-port checks.
module tb_spi_target;
  localparam int NS   = 2;
  localparam int HALF = 8;
`ifdef SPI_TARGET_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  localparam logic [7:0] ID = 8'hA5;

  localparam int K_HRD = 0, K_OE = 1, K_RXB = 2, K_STB = 3, K_MISO = 4;

  typedef struct { logic [7:0] rx; bit chk; logic [7:0] miso; } rx_exp_t;
  typedef struct { int kind; logic [7:0] val; } poll_t;

  logic       CLK = 0, RST = 1, SCK = 0, nSS = 1, MOSI = 0, HWE = 0;
  logic [2:0] HADDR = 0;
  logic [7:0] HWD = 0;
  logic       MISO, MISO_OE, RX_STB;
  logic [7:0] HRD, RX_BYTE;

  spi_target #(.SYNC_STAGES(NS), .ID_BYTE(ID)) dut (
    .CLK(CLK), .RST(RST), .SCK(SCK), .nSS(nSS), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .HADDR(HADDR), .HWE(HWE), .HWD(HWD), .HRD(HRD), .RX_STB(RX_STB), .RX_BYTE(RX_BYTE)
  );

  always #5 CLK = ~CLK;

  rx_exp_t    rx_q[$];
  poll_t      poll_q[$];
  logic [7:0] model[8];
  logic [7:0] miso_cap = 0;
  logic       poll_req = 0, done_req = 0;
  int         vectors = 0, miscompares = 0;
  int         cur_addr;

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    rx_exp_t r;
    poll_t   p;
    if (RX_STB) begin
      if (rx_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_rx_stb: got RX_BYTE=%h, expected no strobe", RX_BYTE);
      end else begin
        r = rx_q.pop_front();
        cmp("rx_byte", RX_BYTE, r.rx);
        if (r.chk) cmp("miso_byte", miso_cap, r.miso);
      end
    end
    if (poll_req && poll_q.size() > 0) begin
      p = poll_q.pop_front();
      case (p.kind)
        K_HRD:   cmp("hrd", HRD, p.val);
        K_OE:    cmp("miso_oe", {7'b0, MISO_OE}, p.val);
        K_RXB:   cmp("rx_byte_hold", RX_BYTE, p.val);
        K_STB:   cmp("rx_stb_idle", {7'b0, RX_STB}, p.val);
        default: cmp("miso_idle", {7'b0, MISO}, p.val);
      endcase
    end
    if (done_req) begin
      cmp("rx_queue_drained", 8'(rx_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic poll(input int kind, input logic [2:0] a, input logic [7:0] v);
    HADDR = a;
    poll_q.push_back('{kind, v});
    poll_req = 1;
    tick();
    poll_req = 0;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    HADDR = a; HWD = d; HWE = 1;
    tick();
    HWE = 0;
    model[a] = d;
  endtask

  // Shifts n bits MSB first; optionally fires HWE in the CLK the 8th bit completes.
  task automatic spi_bits(input logic [7:0] b, input int n, input bit hw,
                          input logic [2:0] ha, input logic [7:0] hd);
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      repeat (HALF) tick();
      SCK = 1;
      miso_cap = {miso_cap[6:0], MISO};
      if (hw && i == 7) begin
        repeat (NS) tick();
        HADDR = ha; HWD = hd; HWE = 1;
        tick();
        HWE = 0;
        repeat (HALF - NS - 1) tick();
      end else begin
        repeat (HALF) tick();
      end
      SCK = 0;
    end
  endtask

  task automatic frame_begin();
    nSS = 0;
    repeat (HALF) tick();
    poll(K_OE, 0, 8'h01);
  endtask

  task automatic frame_end();
    repeat (HALF) tick();
    nSS = 1;
    repeat (HALF + NS + 2) tick();
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_q.push_back('{c, 1'b1, ID});
    cur_addr = int'(c[2:0]);
    spi_bits(c, 8, 0, 0, 0);
  endtask

  task automatic send_wr(input logic [7:0] d, input bit hw, input logic [2:0] ha, input logic [7:0] hd);
    rx_q.push_back('{d, 1'b0, 8'h00});
    if (hw) model[ha] = hd;
    model[cur_addr] = d;
    cur_addr = (cur_addr + INC) % 8;
    spi_bits(d, 8, hw, ha, hd);
  endtask

  task automatic send_rd(input logic [7:0] dummy);
    rx_q.push_back('{dummy, 1'b1, model[cur_addr]});
    cur_addr = (cur_addr + INC) % 8;
    spi_bits(dummy, 8, 0, 0, 0);
  endtask

  task automatic check_all_regs();
    for (int a = 0; a < 8; a++) poll(K_HRD, 3'(a), model[a]);
  endtask

  initial begin
    for (int a = 0; a < 8; a++) model[a] = 8'h00;
    repeat (4) tick();
    RST = 0;
    tick();
    check_all_regs();
    poll(K_OE, 0, 8'h00);
    poll(K_STB, 0, 8'h00);
    poll(K_RXB, 0, 8'h00);
    poll(K_MISO, 0, 8'h00);

    // write burst from reg2
    frame_begin();
    send_cmd(8'h82); send_wr(8'h11, 0, 0, 0); send_wr(8'h22, 0, 0, 0);
    frame_end();
    poll(K_HRD, 3'd2, model[2]);
    poll(K_HRD, 3'd3, model[3]);
    poll(K_RXB, 0, 8'h22);

    // read from reg7, wrapping to reg0
    host_wr(3'd7, 8'h5A);
    host_wr(3'd0, 8'hC3);
    frame_begin();
    send_cmd(8'h07); send_rd(8'h00); send_rd(8'h00);
    frame_end();

    // partial byte is discarded
    frame_begin();
    send_cmd(8'h84);
    spi_bits(8'hFF, 5, 0, 0, 0);
    frame_end();
    poll(K_HRD, 3'd4, model[4]);
    poll(K_RXB, 0, 8'h84);
    frame_begin();
    send_cmd(8'h04); send_rd(8'h3C);
    frame_end();

    // host/SPI collisions: same register then different registers
    frame_begin();
    send_cmd(8'h81); send_wr(8'h55, 1, 3'd1, 8'hAA);
    frame_end();
    poll(K_HRD, 3'd1, 8'h55);
    frame_begin();
    send_cmd(8'h86); send_wr(8'h77, 1, 3'd5, 8'h3C);
    frame_end();
    poll(K_HRD, 3'd5, model[5]);
    poll(K_HRD, 3'd6, model[6]);

    // randomised frames
    for (int f = 0; f < 12; f++) begin
      int nb;
      logic [7:0] c;
      if ($urandom_range(0, 1) == 1) host_wr(3'($urandom_range(0, 7)), 8'($urandom));
      nb = $urandom_range(1, 3);
      c  = 8'($urandom);
      frame_begin();
      send_cmd(c);
      for (int j = 0; j < nb; j++) begin
        if (c[7]) send_wr(8'($urandom), 0, 0, 0);
        else      send_rd(8'($urandom));
      end
      frame_end();
    end
    check_all_regs();

    // reset in the middle of a write data byte
    frame_begin();
    send_cmd(8'h83);
    spi_bits(8'hF0, 4, 0, 0, 0);
    RST = 1;
    repeat (2) tick();
    RST = 0;
    for (int a = 0; a < 8; a++) model[a] = 8'h00;
    spi_bits(8'h0F, 4, 0, 0, 0);
    spi_bits(8'hEE, 8, 0, 0, 0);
    frame_end();
    check_all_regs();
    poll(K_RXB, 0, 8'h00);

    // recovery after reset
    frame_begin();
    send_cmd(8'h80); send_wr(8'h99, 0, 0, 0);
    frame_end();
    check_all_regs();

    repeat (4) tick();
    done_req = 1;
    tick();
    tick();
  end

endmodule
